fxyz_sweep: RTL and testbench

- Sequential stimulus/check stage wrapped around the 3-input AND function s = x & y & z.
- Upstream role: drives x, y, z through all 8 input combinations in ascending order.
- Downstream role: samples the function output s for each vector, builds the captured truth-table column, and compares it against a parameterised expected column.
- Reports a one-cycle done pulse plus pass/fail and mismatch information; results hold until the next sweep.

---
 rtl/fxyz_sweep.sv | 83 ++++++++
 tb/tb_fxyz_sweep.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fxyz_sweep.sv
// rtl/fxyz_sweep.sv - exhaustive 3-input sweep and truth-table check of s = x & y & z
module fxyz_sweep #(
    parameter logic [7:0] EXPECT = 8'b1000_0000,
    parameter int         SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       s,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_out,
    output logic [7:0] mismatch,
    output logic [3:0] err_count
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cnt       <= 4'd0;
            pass      <= 1'b0;
            table_out <= 8'h00;
            mismatch  <= 8'h00;
            err_count <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= 3'd0;
                        cnt       <= 4'd0;
                        pass      <= 1'b0;
                        table_out <= 8'h00;
                        mismatch  <= 8'h00;
                        err_count <= 4'd0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // s is sampled on the last of the SETTLE+1 cycles each vector is held
                    if (cnt == SETTLE_CNT) begin
                        table_out[idx] <= s;
                        mismatch[idx]  <= s ^ EXPECT[idx];
                        if (s != EXPECT[idx]) begin
                            err_count <= err_count + 4'd1;
                        end
                        cnt <= 4'd0;
                        if (idx == 3'd7) begin
                            state <= FIN;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                FIN: begin
                    pass  <= (err_count == 4'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    // idx stays at 7 through FIN, so the last vector is still presented there
    assign {x, y, z} = busy ? idx : 3'd0;

endmodule

// File: tb/tb_fxyz_sweep.sv
// tb/tb_fxyz_sweep.sv - scoreboard bench for fxyz_sweep
module tb_fxyz_sweep;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start0 = 1'b0;
    logic [1:0] mode = 2'd0;

    logic       s1, x1, y1, z1, busy1, done1, pass1;
    logic [7:0] table1, mism1;
    logic [3:0] err1;

    logic       s0, x0, y0, z0, busy0, done0, pass0;
    logic [7:0] table0, mism0;
    logic [3:0] err0;

    typedef struct {
        int         done_cyc;
        logic [7:0] tbl;
        logic [7:0] mism;
        logic [3:0] err;
        logic       pass;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   acc = 0;
    bit   active = 0;
    int   total = 0;
    int   bad = 0;

    // mode 0: correct AND, 1: stuck at 0, 2: stuck at 1
    assign s1 = (mode == 2'd0) ? (x1 & y1 & z1) : (mode == 2'd2);
    assign s0 = x0 & y0 & z0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fxyz_sweep #(.EXPECT(8'b1000_0000), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .s(s1),
        .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .pass(pass1),
        .table_out(table1), .mismatch(mism1), .err_count(err1)
    );

    fxyz_sweep #(.EXPECT(8'b1000_0000), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .s(s0),
        .x(x0), .y(y0), .z(z0), .busy(busy0), .done(done0), .pass(pass0),
        .table_out(table0), .mismatch(mism0), .err_count(err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse of the SETTLE=1 instance
    bit   pend_pass = 0;
    logic exp_pass;
    always @(negedge clk) begin
        if (rst_n) begin
            if (done1) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("table_out", table1, e.tbl);
                    chk("mismatch", mism1, e.mism);
                    chk("err_count", err1, e.err);
                    chk("xyz_fin", {x1, y1, z1}, 3'b111);
                    exp_pass  = e.pass;
                    pend_pass = 1;
                end
                active = 0;
            end else begin
                if (pend_pass) begin
                    chk("pass", pass1, exp_pass);
                    chk("done_width", done1, 0);
                    pend_pass = 0;
                end
                if (active && busy1) begin
                    chk("xyz_step", {x1, y1, z1}, (cyc - acc) / 2);
                end
            end
        end
    end

    task automatic wait_idle1();
        int n = 0;
        while (busy1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy1) chk("idle_timeout", 1, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] m, input logic [7:0] tbl,
                         input logic [7:0] mm, input logic [3:0] ec, input bit start_at3);
        exp_t e;
        @(negedge clk);
        mode   = m;
        start1 = 1'b1;
        acc    = cyc + 1;
        active = 1;
        e.done_cyc = acc + 16;
        e.tbl  = tbl;
        e.mism = mm;
        e.err  = ec;
        e.pass = (ec == 4'd0);
        q.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        if (start_at3) begin
            int n = 0;
            while ({x1, y1, z1} != 3'd3 && n < 40) begin
                @(negedge clk);
                n++;
            end
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
        end
    endtask

    initial begin
        #12;
        chk("rst_busy", busy1, 0);
        chk("rst_outs", {x1, y1, z1, done1, pass1, table1, mism1, err1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'd0, 8'h80, 8'h00, 4'd0, 0); wait_idle1();
        issue(2'd1, 8'h00, 8'h80, 4'd1, 0); wait_idle1();
        issue(2'd2, 8'hFF, 8'h7F, 4'd7, 0); wait_idle1();
        issue(2'd0, 8'h80, 8'h00, 4'd0, 1); wait_idle1();
        repeat (4) @(negedge clk);
        chk("no_restart", busy1, 0);

        // Asynchronous reset while idx = 4
        begin
            int n = 0;
            @(negedge clk);
            mode   = 2'd0;
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            while ({x1, y1, z1} != 3'd4 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("reach_idx4", {x1, y1, z1}, 3'd4);
            #2;
            rst_n = 1'b0;
            q.delete();
            active = 0;
            #1;
            chk("arst_busy", busy1, 0);
            chk("arst_outs", {x1, y1, z1, done1, pass1, table1, mism1, err1}, 0);
            @(negedge clk);
            rst_n = 1'b1;
        end
        issue(2'd0, 8'h80, 8'h00, 4'd0, 0); wait_idle1();

        // SETTLE = 0 instance
        begin
            int c0, n;
            @(negedge clk);
            start0 = 1'b1;
            c0 = cyc + 1;
            @(negedge clk);
            start0 = 1'b0;
            n = 0;
            while (!done0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("s0_done_cycle", cyc - c0, 8);
            chk("s0_table_out", table0, 8'h80);
            chk("s0_err_count", err0, 4'd0);
            @(negedge clk);
            chk("s0_pass", pass0, 1);
        end

        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
